// File: rtl/rn_axi_noc_bridge.sv
// Requester-node bridge: AXI4 master <-> NoC AW/W/B/AR/R flit channels.
// Optional outstanding-transaction limiter under `RN_OUTS_LIMIT_EN.
module rn_axi_noc_bridge #(
  parameter int ID_W     = 11,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int TGT_W    = 2,
  parameter int FLIT_W   = 82,
  parameter int WQ_DEPTH = 4,
  parameter int MAX_OUTS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_ready,
  output logic                aw_valid,
  output logic [FLIT_W-1:0]   aw_payload,
  output logic [TGT_W-1:0]    aw_tgtid,
  input  logic                w_ready,
  output logic                w_valid,
  output logic                w_head,
  output logic                w_tail,
  output logic [FLIT_W-1:0]   w_payload,
  output logic [TGT_W-1:0]    w_tgtid,
  output logic                b_ready,
  input  logic                b_valid,
  input  logic [19:0]         b_payload,
  input  logic [TGT_W-1:0]    b_srcid,
  input  logic                ar_ready,
  output logic                ar_valid,
  output logic [FLIT_W-1:0]   ar_payload,
  output logic [TGT_W-1:0]    ar_tgtid,
  output logic                r_ready,
  input  logic                r_valid,
  input  logic                r_head,
  input  logic                r_tail,
  input  logic [FLIT_W-1:0]   r_payload,
  input  logic [TGT_W-1:0]    r_srcid,
  output logic                AWREADY,
  input  logic                AWVALID,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWREGION,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWLOCK,
  input  logic [3:0]          AWCACHE,
  input  logic [2:0]          AWPROT,
  input  logic [3:0]          AWQOS,
  input  logic [3:0]          AWUSER,
  output logic                ARREADY,
  input  logic                ARVALID,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARREGION,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARLOCK,
  input  logic [3:0]          ARCACHE,
  input  logic [2:0]          ARPROT,
  input  logic [3:0]          ARQOS,
  input  logic [3:0]          ARUSER,
  output logic                WREADY,
  input  logic                WVALID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic [3:0]          WUSER,
  input  logic                BREADY,
  output logic                BVALID,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic [3:0]          BUSER,
  input  logic                RREADY,
  output logic                RVALID,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic [3:0]          RUSER
);

  localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic             wq_full;
  logic             wq_empty;
  logic             wr_lim;
  logic             rd_lim;
  logic             aw_ok;
  logic             ar_ok;
  logic             aw_hs;
  logic             ar_hs;
  logic             w_hs;
  logic             w_pop;
  logic             b_hs;
  logic             r_end;

  logic [TGT_W-1:0] wq_q [WQ_DEPTH];
  logic [TGT_W-1:0] wq_d [WQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_beat_q, first_beat_d;

  assign aw_ok    = !wq_full && !wr_lim;
  assign ar_ok    = !rd_lim;
  assign aw_valid = AWVALID && aw_ok;
  assign AWREADY  = aw_ready && aw_ok;
  assign ar_valid = ARVALID && ar_ok;
  assign ARREADY  = ar_ready && ar_ok;
  assign aw_tgtid = AWADDR[ADDR_W-1 -: TGT_W];
  assign ar_tgtid = ARADDR[ADDR_W-1 -: TGT_W];

  assign aw_payload = FLIT_W'({AWID, AWADDR, AWREGION, AWLEN, AWSIZE,
                               AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
                               AWUSER});
  assign ar_payload = FLIT_W'({ARID, ARADDR, ARREGION, ARLEN, ARSIZE,
                               ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
                               ARUSER});
  assign w_payload  = FLIT_W'({WDATA, WSTRB, WLAST, WUSER});

  assign aw_hs = AWVALID && AWREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign w_hs  = WVALID && WREADY;
  assign w_pop = w_hs && WLAST;
  assign b_hs  = b_valid && BREADY;
  assign r_end = r_valid && RREADY && r_tail;

  assign wq_empty = (cnt_q == '0);
  assign wq_full  = (cnt_q == CNT_W'(WQ_DEPTH));

  assign w_valid = WVALID && !wq_empty;
  assign WREADY  = w_ready && !wq_empty;
  assign w_tgtid = wq_empty ? '0 : wq_q[rd_ptr_q];
  assign w_head  = first_beat_q && w_valid;
  assign w_tail  = WLAST && w_valid;

  always_comb begin
    wq_d         = wq_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    first_beat_d = first_beat_q;
    if (aw_hs) begin
      wq_d[wr_ptr_q] = aw_tgtid;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({aw_hs, w_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (w_hs) begin
      first_beat_d = WLAST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      first_beat_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      first_beat_q <= first_beat_d;
    end
  end

  // Entry storage needs no reset: it is only read while occupied.
  always_ff @(posedge clk) begin
    wq_q <= wq_d;
  end

`ifdef RN_OUTS_LIMIT_EN
  localparam int OC_W = $clog2(MAX_OUTS + 1);

  logic [OC_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [OC_W-1:0] rd_cnt_q, rd_cnt_d;
  logic            wr_dec;
  logic            rd_dec;

  assign wr_dec = b_hs && (wr_cnt_q != '0);
  assign rd_dec = r_end && (rd_cnt_q != '0);
  assign wr_lim = (wr_cnt_q == OC_W'(MAX_OUTS));
  assign rd_lim = (rd_cnt_q == OC_W'(MAX_OUTS));

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    unique case ({aw_hs, wr_dec})
      2'b10:   wr_cnt_d = wr_cnt_q + OC_W'(1);
      2'b01:   wr_cnt_d = wr_cnt_q - OC_W'(1);
      default: wr_cnt_d = wr_cnt_q;
    endcase
    unique case ({ar_hs, rd_dec})
      2'b10:   rd_cnt_d = rd_cnt_q + OC_W'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - OC_W'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
`else
  assign wr_lim = 1'b0;
  assign rd_lim = 1'b0;

  logic unused_hs;
  assign unused_hs = ^{ar_hs, b_hs, r_end};
`endif

  assign BVALID  = b_valid;
  assign b_ready = BREADY;
  assign BID     = b_payload[ID_W+5:6];
  assign BRESP   = b_payload[5:4];
  assign BUSER   = b_payload[3:0];

  assign RVALID  = r_valid;
  assign r_ready = RREADY;
  assign RID     = r_payload[ID_W+DATA_W+5:DATA_W+6];
  assign RDATA   = r_payload[DATA_W+5:6];
  assign RRESP   = r_payload[5:4];
  assign RUSER   = r_payload[3:0];
  assign RLAST   = r_tail;

  // Source IDs, r_head and padding bits of the inbound flits carry nothing here.
  logic unused_in;
  assign unused_in = ^{b_payload, r_payload, r_head, b_srcid, r_srcid};

endmodule
